// File: rtl/bp_pkg.sv
// Shared constants and helpers for the branch predictor: FSM encoding,
// counter init/saturation values and packed table-entry field layout.
package bp_pkg;

    typedef enum logic [0:0] {
        CLEAR = 1'b0,
        RUN   = 1'b1
    } bp_state_e;

    // Largest value of a w-bit saturating counter.
    function automatic logic [31:0] cnt_max_f(input int unsigned w);
        return (32'd1 << w) - 32'd1;
    endfunction

    // Weakly-taken allocation value: only the counter MSB set.
    function automatic logic [31:0] cnt_init_f(input int unsigned w);
        return 32'd1 << (w - 32'd1);
    endfunction

    // Entry layout, LSB first: target, counter, tag, valid.
    function automatic int unsigned cnt_lsb_f(input int unsigned pc_w);
        return pc_w;
    endfunction

    function automatic int unsigned tag_lsb_f(input int unsigned pc_w, input int unsigned cnt_w);
        return pc_w + cnt_w;
    endfunction

    function automatic int unsigned valid_bit_f(input int unsigned pc_w, input int unsigned cnt_w,
                                                input int unsigned tag_w);
        return pc_w + cnt_w + tag_w;
    endfunction

endpackage

// File: rtl/bp_entry_next.sv
// Next-entry calculation for one resolved branch: tag hit test, counter
// saturation and the allocate-on-taken rule.
module bp_entry_next
    import bp_pkg::*;
#(
    parameter int PC_W  = 13,
    parameter int CNT_W = 2,
    parameter int TAG_W = 5,
    parameter int ENT_W = PC_W + CNT_W + TAG_W + 1
) (
    input  logic [ENT_W-1:0] cur_entry,
    input  logic [TAG_W-1:0] upd_tag,
    input  logic             upd_taken,
    input  logic [PC_W-1:0]  upd_target,
    output logic             wr,
    output logic [ENT_W-1:0] nxt_entry
);

    localparam int CNT_LSB = cnt_lsb_f(PC_W);
    localparam int TAG_LSB = tag_lsb_f(PC_W, CNT_W);
    localparam int V_BIT   = valid_bit_f(PC_W, CNT_W, TAG_W);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(cnt_max_f(CNT_W));
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(cnt_init_f(CNT_W));

    logic             cur_valid_s;
    logic [TAG_W-1:0] cur_tag_s;
    logic [CNT_W-1:0] cur_cnt_s;
    logic [PC_W-1:0]  cur_tgt_s;
    logic [CNT_W-1:0] cnt_sat_s;

    assign cur_valid_s = cur_entry[V_BIT];
    assign cur_tag_s   = cur_entry[TAG_LSB +: TAG_W];
    assign cur_cnt_s   = cur_entry[CNT_LSB +: CNT_W];
    assign cur_tgt_s   = cur_entry[0 +: PC_W];

    // Saturating step of the taken counter toward the actual outcome.
    always_comb begin
        cnt_sat_s = cur_cnt_s;
        if (upd_taken) begin
            if (cur_cnt_s != CNT_MAX) begin
                cnt_sat_s = cur_cnt_s + CNT_W'(1);
            end else begin
                cnt_sat_s = cur_cnt_s;
            end
        end else begin
            if (cur_cnt_s != {CNT_W{1'b0}}) begin
                cnt_sat_s = cur_cnt_s - CNT_W'(1);
            end else begin
                cnt_sat_s = cur_cnt_s;
            end
        end
    end

    // Hit trains the entry; a taken miss replaces it; a not-taken miss is dropped.
    always_comb begin
        wr        = 1'b0;
        nxt_entry = cur_entry;
        if (cur_valid_s && (cur_tag_s == upd_tag)) begin
            wr        = 1'b1;
            nxt_entry = {1'b1, cur_tag_s, cnt_sat_s, (upd_taken ? upd_target : cur_tgt_s)};
        end else if (upd_taken) begin
            wr        = 1'b1;
            nxt_entry = {1'b1, upd_tag, CNT_INIT, upd_target};
        end else begin
            wr        = 1'b0;
            nxt_entry = cur_entry;
        end
    end

endmodule

// File: rtl/branch_predictor.sv
// Direct-mapped tagged branch predictor: LOOKUPS registered read ports,
// one write-first update port and a reset-time invalidation sweep.
module branch_predictor
    import bp_pkg::*;
#(
    parameter int PC_W    = 13,
    parameter int ENTRIES = 256,
    parameter int CNT_W   = 2,
    parameter int LOOKUPS = 2
) (
    input  logic                    CLK,
    input  logic                    RST,
    input  logic [LOOKUPS-1:0]      lk_valid,
    input  logic [LOOKUPS*PC_W-1:0] lk_pc,
    output logic [LOOKUPS-1:0]      pred_hit,
    output logic [LOOKUPS-1:0]      pred_taken,
    output logic [LOOKUPS*PC_W-1:0] pred_target,
    input  logic                    upd_en,
    input  logic [PC_W-1:0]         upd_pc,
    input  logic                    upd_taken,
    input  logic [PC_W-1:0]         upd_target,
    output logic                    ready
);

    localparam int IDX_W   = $clog2(ENTRIES);
    localparam int TAG_W   = PC_W - IDX_W;
    localparam int CNT_LSB = cnt_lsb_f(PC_W);
    localparam int TAG_LSB = tag_lsb_f(PC_W, CNT_W);
    localparam int V_BIT   = valid_bit_f(PC_W, CNT_W, TAG_W);
    localparam int ENT_W   = V_BIT + 1;

    logic [ENT_W-1:0]        table_r [ENTRIES];
    bp_state_e               state_r, state_next_s;
    logic [IDX_W-1:0]        ptr_r, ptr_next_s;
    logic                    ready_r;
    logic [IDX_W-1:0]        upd_idx_s;
    logic                    upd_wr_s, wr_en_s;
    logic [ENT_W-1:0]        upd_next_s;
    logic [LOOKUPS-1:0]      hit_s, taken_s, hit_r, taken_r;
    logic [LOOKUPS*PC_W-1:0] tgt_s, tgt_r;

    assign upd_idx_s = upd_pc[IDX_W-1:0];

    bp_entry_next #(
        .PC_W  (PC_W),
        .CNT_W (CNT_W),
        .TAG_W (TAG_W),
        .ENT_W (ENT_W)
    ) u_entry_next (
        .cur_entry  (table_r[upd_idx_s]),
        .upd_tag    (upd_pc[PC_W-1:IDX_W]),
        .upd_taken  (upd_taken),
        .upd_target (upd_target),
        .wr         (upd_wr_s),
        .nxt_entry  (upd_next_s)
    );

    assign wr_en_s = (state_r == RUN) && upd_en && upd_wr_s;

    // Sweep and run-state register.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_r <= CLEAR;
            ptr_r   <= {IDX_W{1'b0}};
            ready_r <= 1'b0;
        end else begin
            state_r <= state_next_s;
            ptr_r   <= ptr_next_s;
            ready_r <= (state_next_s == RUN);
        end
    end

    // Advance the clear pointer; leave CLEAR once the last entry is invalidated.
    always_comb begin
        state_next_s = state_r;
        ptr_next_s   = ptr_r;
        case (state_r)
            CLEAR: begin
                ptr_next_s = ptr_r + IDX_W'(1);
                if (ptr_r == IDX_W'(ENTRIES - 1)) begin
                    state_next_s = RUN;
                end else begin
                    state_next_s = CLEAR;
                end
            end
            RUN: begin
                state_next_s = RUN;
                ptr_next_s   = ptr_r;
            end
            default: begin
                state_next_s = CLEAR;
                ptr_next_s   = {IDX_W{1'b0}};
            end
        endcase
    end

    // Single table write port: sweep invalidation or resolved-branch update.
    always_ff @(posedge CLK) begin
        if (!RST) begin
            if (state_r == CLEAR) begin
                table_r[ptr_r][V_BIT] <= 1'b0;
            end else if (wr_en_s) begin
                table_r[upd_idx_s] <= upd_next_s;
            end
        end
    end

    // Per-slot read with write-first bypass of the same-cycle update.
    always_comb begin
        hit_s   = {LOOKUPS{1'b0}};
        taken_s = {LOOKUPS{1'b0}};
        tgt_s   = {(LOOKUPS*PC_W){1'b0}};
        for (int i = 0; i < LOOKUPS; i++) begin
            logic [PC_W-1:0]  pc_v;
            logic [ENT_W-1:0] ent_v;
            pc_v = lk_pc[i*PC_W +: PC_W];
            if (wr_en_s && (pc_v[IDX_W-1:0] == upd_idx_s)) begin
                ent_v = upd_next_s;
            end else begin
                ent_v = table_r[pc_v[IDX_W-1:0]];
            end
            if (lk_valid[i] && (state_r == RUN) && ent_v[V_BIT] &&
                (ent_v[TAG_LSB +: TAG_W] == pc_v[PC_W-1:IDX_W])) begin
                hit_s[i]               = 1'b1;
                taken_s[i]             = ent_v[CNT_LSB + CNT_W - 1];
                tgt_s[i*PC_W +: PC_W]  = ent_v[0 +: PC_W];
            end else begin
                hit_s[i]               = 1'b0;
                taken_s[i]             = 1'b0;
                tgt_s[i*PC_W +: PC_W]  = {PC_W{1'b0}};
            end
        end
    end

    // Registered prediction outputs.
    always_ff @(posedge CLK) begin
        if (RST) begin
            hit_r   <= {LOOKUPS{1'b0}};
            taken_r <= {LOOKUPS{1'b0}};
            tgt_r   <= {(LOOKUPS*PC_W){1'b0}};
        end else begin
            hit_r   <= hit_s;
            taken_r <= taken_s;
            tgt_r   <= tgt_s;
        end
    end

    assign pred_hit    = hit_r;
    assign pred_taken  = taken_r;
    assign pred_target = tgt_r;
    assign ready       = ready_r;

endmodule

// File: tb/tb_branch_predictor.sv
// Directed self-checking bench for branch_predictor (PC_W=13, 256 entries,
// 2-bit counters, two lookup slots).
module tb_branch_predictor;

    localparam int PC_W    = 13;
    localparam int ENTRIES = 256;

    logic              CLK = 1'b0;
    logic              RST;
    logic [1:0]        lk_valid;
    logic [2*PC_W-1:0] lk_pc;
    logic [1:0]        pred_hit;
    logic [1:0]        pred_taken;
    logic [2*PC_W-1:0] pred_target;
    logic              upd_en;
    logic [PC_W-1:0]   upd_pc;
    logic              upd_taken;
    logic [PC_W-1:0]   upd_target;
    logic              ready;

    int tests  = 0;
    int failed = 0;

    branch_predictor #(
        .PC_W    (PC_W),
        .ENTRIES (ENTRIES),
        .CNT_W   (2),
        .LOOKUPS (2)
    ) dut (
        .CLK         (CLK),
        .RST         (RST),
        .lk_valid    (lk_valid),
        .lk_pc       (lk_pc),
        .pred_hit    (pred_hit),
        .pred_taken  (pred_taken),
        .pred_target (pred_target),
        .upd_en      (upd_en),
        .upd_pc      (upd_pc),
        .upd_taken   (upd_taken),
        .upd_target  (upd_target),
        .ready       (ready)
    );

    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_slot(input string tag, input int s, input logic hit,
                            input logic taken, input logic [PC_W-1:0] tgt);
        chk({tag, "_hit"},    32'(pred_hit[s]),   32'(hit));
        chk({tag, "_taken"},  32'(pred_taken[s]), 32'(taken));
        chk({tag, "_target"}, 32'(pred_target[s*PC_W +: PC_W]), 32'(tgt));
    endtask

    task automatic upd(input logic [PC_W-1:0] pc, input logic t, input logic [PC_W-1:0] tgt);
        upd_en     = 1'b1;
        upd_pc     = pc;
        upd_taken  = t;
        upd_target = tgt;
    endtask

    task automatic lk(input logic v0, input logic [PC_W-1:0] pc0,
                      input logic v1, input logic [PC_W-1:0] pc1);
        lk_valid = {v1, v0};
        lk_pc    = {pc1, pc0};
    endtask

    task automatic idle();
        upd_en   = 1'b0;
        lk_valid = 2'b00;
    endtask

    logic       sat_t   [10] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    logic       sat_exp [10] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};

    initial begin
        RST = 1'b1;
        idle();
        upd_pc = '0; upd_taken = 1'b0; upd_target = '0; lk_pc = '0;
        tick();
        chk("rst_ready", 32'(ready), 32'd0);
        chk_slot("rst_s0", 0, 1'b0, 1'b0, 13'h000);

        // Sweep: ready low for ENTRIES cycles; lookups during sweep miss.
        RST = 1'b0;
        lk(1'b1, 13'h005, 1'b0, 13'h000);
        tick();
        chk("sweep_ready_first", 32'(ready), 32'd0);
        chk_slot("sweep_lk", 0, 1'b0, 1'b0, 13'h000);
        for (int k = 2; k < ENTRIES; k++) tick();
        chk("sweep_ready_last", 32'(ready), 32'd0);
        chk_slot("sweep_lk_last", 0, 1'b0, 1'b0, 13'h000);
        tick();
        chk("sweep_ready_up", 32'(ready), 32'd1);
        idle();

        // Allocate on taken miss.
        upd(13'h010, 1'b1, 13'h040);
        tick();
        idle();
        lk(1'b1, 13'h010, 1'b1, 13'h011);
        tick();
        chk_slot("alloc_s0", 0, 1'b1, 1'b1, 13'h040);
        chk_slot("alloc_s1", 1, 1'b0, 1'b0, 13'h000);

        // Saturation walk from counter 2, observed through the bypass.
        for (int k = 0; k < 10; k++) begin
            upd(13'h010, sat_t[k], sat_t[k] ? 13'h040 : 13'h1FFF);
            lk(1'b1, 13'h010, 1'b0, 13'h010);
            tick();
            chk($sformatf("sat_step%0d_taken", k), 32'(pred_taken[0]), 32'(sat_exp[k]));
        end
        chk_slot("sat_tgt_kept", 0, 1'b1, 1'b0, 13'h040);
        chk_slot("invalid_slot1", 1, 1'b0, 1'b0, 13'h000);
        idle();

        // Aliasing on index 0x10 with different tags.
        upd(13'h110, 1'b1, 13'h0AA);
        tick();
        idle();
        lk(1'b1, 13'h010, 1'b1, 13'h110);
        tick();
        chk_slot("alias_old", 0, 1'b0, 1'b0, 13'h000);
        chk_slot("alias_new", 1, 1'b1, 1'b1, 13'h0AA);
        idle();
        upd(13'h210, 1'b0, 13'h123);
        tick();
        idle();
        lk(1'b1, 13'h110, 1'b1, 13'h210);
        tick();
        chk_slot("nt_miss_keep", 0, 1'b1, 1'b1, 13'h0AA);
        chk_slot("nt_miss_none", 1, 1'b0, 1'b0, 13'h000);

        // Bypass into both slots on the same index.
        upd(13'h020, 1'b1, 13'h100);
        lk(1'b1, 13'h020, 1'b1, 13'h020);
        tick();
        chk_slot("bypass_s0", 0, 1'b1, 1'b1, 13'h100);
        chk_slot("bypass_s1", 1, 1'b1, 1'b1, 13'h100);
        idle();

        // Reset mid-RUN, then again mid-CLEAR at pointer 3.
        RST = 1'b1;
        lk(1'b1, 13'h110, 1'b1, 13'h020);
        tick();
        chk("rrun_ready", 32'(ready), 32'd0);
        chk_slot("rrun_s0", 0, 1'b0, 1'b0, 13'h000);
        RST = 1'b0;
        tick(); tick(); tick();
        RST = 1'b1;
        tick();
        RST = 1'b0;
        for (int k = 1; k < ENTRIES; k++) tick();
        chk("rclr_ready_last", 32'(ready), 32'd0);
        tick();
        chk("rclr_ready_up", 32'(ready), 32'd1);
        tick();
        chk_slot("rclr_s0", 0, 1'b0, 1'b0, 13'h000);
        chk_slot("rclr_s1", 1, 1'b0, 1'b0, 13'h000);
        idle();

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
